// File: rtl/csr_rmw_unit_pkg.sv
// rtl/csr_rmw_unit_pkg.sv - shared constants, state encoding and CSR address list for csr_rmw_unit
package csr_rmw_unit_pkg;

   localparam int CSR_XLEN = 32;

   localparam logic [2:0] F3_CSRRW  = 3'b001;
   localparam logic [2:0] F3_CSRRS  = 3'b010;
   localparam logic [2:0] F3_CSRRC  = 3'b011;
   localparam logic [2:0] F3_CSRRWI = 3'b101;
   localparam logic [2:0] F3_CSRRSI = 3'b110;
   localparam logic [2:0] F3_CSRRCI = 3'b111;

   localparam int N_IMPL_CSR = 8;
   localparam logic [11:0] IMPL_CSR_ADDRS [N_IMPL_CSR] = '{
      12'h300, 12'h304, 12'h305, 12'h340,
      12'h341, 12'h342, 12'h343, 12'h344
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   function automatic logic csr_is_implemented(input logic [11:0] addr);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < N_IMPL_CSR; i++) begin
         if (addr == IMPL_CSR_ADDRS[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/csr_rmw_unit_csr_alu.sv
// rtl/csr_rmw_unit_csr_alu.sv - combinational new-value and write-needed logic for Zicsr ops
module csr_alu
   import csr_rmw_unit_pkg::*;
#(
   parameter int XLEN = CSR_XLEN
) (
   input  logic [1:0]      op,
   input  logic [4:0]      rs1_idx,
   input  logic [XLEN-1:0] old_value,
   input  logic [XLEN-1:0] operand,
   output logic [XLEN-1:0] new_value,
   output logic            write_needed
);

   always_comb begin
      new_value = old_value;
      unique case (op)
         2'b01:   new_value = operand;
         2'b10:   new_value = old_value | operand;
         2'b11:   new_value = old_value & ~operand;
         default: new_value = old_value;
      endcase
      // set/clear with x0 (or zimm 0) must not touch the CSR
      write_needed = (op == 2'b01) || (rs1_idx != 5'd0);
   end

endmodule

// File: rtl/csr_rmw_unit.sv
// rtl/csr_rmw_unit.sv - Zicsr read-modify-write sequencer in front of the CSR register file
// Define CSR_RMW_ADDR_CHECK_EN to treat unimplemented addresses and read-only-space writes as illegal.
module csr_rmw_unit
   import csr_rmw_unit_pkg::*;
#(
   parameter int XLEN = CSR_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_funct3,
   input  logic [11:0]     req_addr,
   input  logic [4:0]      req_rs1,
   input  logic [XLEN-1:0] req_rs1_data,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_illegal,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            csr_we,
   input  logic [XLEN-1:0] csr_rdata
);

   state_t            state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [4:0]        rs1_q, rs1_d;
   logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
   logic [XLEN-1:0]   old_q, old_d;
   logic              illegal_q, illegal_d;
   logic [11:0]       csr_addr_q, csr_addr_d;
   logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
   logic              csr_we_q, csr_we_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic              rsp_illegal_q, rsp_illegal_d;

   logic [XLEN-1:0]   operand;
   logic [XLEN-1:0]   alu_new;
   logic              alu_write_needed;
   logic              illegal_c;

   assign operand = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_q} : rs1_data_q;

   csr_alu #(.XLEN(XLEN)) u_csr_alu (
      .op           (funct3_q[1:0]),
      .rs1_idx      (rs1_q),
      .old_value    (csr_rdata),
      .operand      (operand),
      .new_value    (alu_new),
      .write_needed (alu_write_needed)
   );

   always_comb begin
      illegal_c = (funct3_q[1:0] == 2'b00);
`ifdef CSR_RMW_ADDR_CHECK_EN
      if (!csr_is_implemented(csr_addr_q)) illegal_c = 1'b1;
      if (alu_write_needed && (csr_addr_q[11:10] == 2'b11)) illegal_c = 1'b1;
`endif
   end

   always_comb begin
      state_d       = state_q;
      funct3_d      = funct3_q;
      rs1_d         = rs1_q;
      rs1_data_d    = rs1_data_q;
      old_d         = old_q;
      illegal_d     = illegal_q;
      csr_addr_d    = csr_addr_q;
      csr_wdata_d   = csr_wdata_q;
      csr_we_d      = 1'b0;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_illegal_d = rsp_illegal_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               funct3_d   = req_funct3;
               rs1_d      = req_rs1;
               rs1_data_d = req_rs1_data;
               csr_addr_d = req_addr;
               state_d    = ST_READ;
            end
         end
         ST_READ: begin
            // csr_addr_q is already on the bus, so csr_rdata is valid now;
            // the write strobe is registered here so it lands in WRITE.
            old_d     = csr_rdata;
            illegal_d = illegal_c;
            if (alu_write_needed && !illegal_c) begin
               csr_we_d    = 1'b1;
               csr_wdata_d = alu_new;
            end
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            rsp_valid_d   = 1'b1;
            rsp_illegal_d = illegal_q;
            rsp_rdata_d   = illegal_q ? '0 : old_q;
            state_d       = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         funct3_q      <= '0;
         rs1_q         <= '0;
         rs1_data_q    <= '0;
         old_q         <= '0;
         illegal_q     <= 1'b0;
         csr_addr_q    <= '0;
         csr_wdata_q   <= '0;
         csr_we_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         funct3_q      <= funct3_d;
         rs1_q         <= rs1_d;
         rs1_data_q    <= rs1_data_d;
         old_q         <= old_d;
         illegal_q     <= illegal_d;
         csr_addr_q    <= csr_addr_d;
         csr_wdata_q   <= csr_wdata_d;
         csr_we_q      <= csr_we_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_illegal_q <= rsp_illegal_d;
      end
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_illegal = rsp_illegal_q;
   assign csr_addr    = csr_addr_q;
   assign csr_wdata   = csr_wdata_q;
   // a reset landing in the WRITE cycle must kill the strobe already in flight
   assign csr_we      = csr_we_q & ~rst;

endmodule

// File: tb/tb_csr_rmw_unit.sv
// tb/tb_csr_rmw_unit.sv - scoreboard bench for csr_rmw_unit with a behavioural CSR model
module tb_csr_rmw_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [11:0] req_addr;
   logic [4:0]  req_rs1;
   logic [31:0] req_rs1_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_illegal;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        csr_we;
   logic [31:0] csr_rdata;

   csr_rmw_unit #(.XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_rs1      (req_rs1),
      .req_rs1_data (req_rs1_data),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_illegal  (rsp_illegal),
      .csr_addr     (csr_addr),
      .csr_wdata    (csr_wdata),
      .csr_we       (csr_we),
      .csr_rdata    (csr_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // CSR register file environment
   logic [31:0] mem [0:4095];
   logic        mem_clr;
   logic        pre_we;
   logic [11:0] pre_addr;
   logic [31:0] pre_data;
   assign csr_rdata = mem[csr_addr];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      end else if (pre_we) begin
         mem[pre_addr] <= pre_data;
      end else if (csr_we) begin
         mem[csr_addr] <= csr_wdata;
      end
   end

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
      int          acc;
   } wexp_t;
   typedef struct {
      logic [31:0] rdata;
      logic        illegal;
      int          acc;
   } rexp_t;

   wexp_t wq[$];
   rexp_t rq[$];
   logic [31:0] ref_mem [0:4095];

   int n_pass = 0;
   int n_total = 0;
   int n_writes = 0;
   logic [31:0] last_rdata;
   logic        last_illegal;
   logic [31:0] last_wdata;
   int rdy_mode = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
   endtask

   // Reference: Zicsr semantics applied to a shadow CSR array
   task automatic model(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                        input logic [31:0] data, output logic ill, output logic [31:0] rdata,
                        output logic we, output logic [31:0] wdata);
      logic [31:0] op;
      logic [31:0] old;
      logic        need;
      op   = f3[2] ? 32'(rs1) : data;
      old  = ref_mem[addr];
      ill  = (f3 == 3'd0) || (f3 == 3'd4);
      need = (f3 == 3'd1) || (f3 == 3'd5) || (rs1 != 5'd0);
`ifdef CSR_RMW_ADDR_CHECK_EN
      if (!(addr inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344}))
         ill = 1'b1;
      if (need && addr >= 12'hC00) ill = 1'b1;
`endif
      case (f3)
         3'd1, 3'd5: wdata = op;
         3'd2, 3'd6: wdata = old | op;
         3'd3, 3'd7: wdata = old & ~op;
         default:    wdata = old;
      endcase
      we    = need && !ill;
      rdata = ill ? 32'h0 : old;
   endtask

   // Monitor: write strobes and responses against the expectation queues
   logic        in_rsp = 1'b0;
   logic [31:0] hold_rdata;
   logic        hold_ill;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            in_rsp = 1'b0;
         end else begin
            if (csr_we) begin
               n_writes++;
               last_wdata = csr_wdata;
               if (wq.size() == 0) begin
                  check("unexpected_csr_we", 32'd1, 32'd0);
               end else begin
                  wexp_t w;
                  w = wq.pop_front();
                  check("csr_addr", 32'(csr_addr), 32'(w.addr));
                  check("csr_wdata", csr_wdata, w.data);
                  check("we_latency", 32'(cyc - w.acc), 32'd2);
               end
            end
            if (rsp_valid) begin
               if (!in_rsp) begin
                  in_rsp     = 1'b1;
                  hold_rdata = rsp_rdata;
                  hold_ill   = rsp_illegal;
                  if (rq.size() == 0) begin
                     check("unexpected_rsp", 32'd1, 32'd0);
                  end else begin
                     check("rsp_rdata", rsp_rdata, rq[0].rdata);
                     check("rsp_illegal", 32'(rsp_illegal), 32'(rq[0].illegal));
                     check("rsp_latency", 32'(cyc - rq[0].acc), 32'd3);
                  end
               end else begin
                  check("rsp_rdata_stable", rsp_rdata, hold_rdata);
                  check("rsp_illegal_stable", 32'(rsp_illegal), 32'(hold_ill));
               end
               if (rsp_ready) begin
                  if (rq.size() != 0) void'(rq.pop_front());
                  in_rsp       = 1'b0;
                  last_rdata   = rsp_rdata;
                  last_illegal = rsp_illegal;
               end
            end
         end
      end
   end

   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       rsp_ready = ($urandom_range(0, 3) != 0);
            2:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
         endcase
      end
   end

   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      ref_mem[a] = d;
      @(posedge clk);
      #1;
      pre_we = 1'b0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the request is taken
   task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                        input logic [31:0] d);
      logic ill, we;
      logic [31:0] rd, wd;
      int n;
      req_valid    = 1'b1;
      req_funct3   = f3;
      req_addr     = a;
      req_rs1      = rs1;
      req_rs1_data = d;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
      end else begin
         model(f3, a, rs1, d, ill, rd, we, wd);
         rq.push_back('{rdata: rd, illegal: ill, acc: cyc});
         if (we) begin
            wq.push_back('{addr: a, data: wd, acc: cyc});
            ref_mem[a] = wd;
         end
      end
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
      req_funct3   = 3'($urandom);
      req_addr     = 12'($urandom);
      req_rs1      = 5'($urandom);
      req_rs1_data = $urandom;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(wq.size() == 0 && rq.size() == 0 && req_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(wq.size() == 0 && rq.size() == 0 && req_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nw;
      logic [11:0] addrs [10];
      addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                12'h7C0, 12'hC00};
      for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
      rst = 1'b1; mem_clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_rs1 = '0; req_rs1_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; mem_clr = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
      check("rst_csr_addr", 32'(csr_addr), 32'd0);
      check("rst_csr_wdata", csr_wdata, 32'd0);
      check("rst_csr_we", 32'(csr_we), 32'd0);
      @(posedge clk);
      #1;

      issue(3'b001, 12'h305, 5'd1, 32'h8000_0100);
      wait_idle();
      check("t1_rdata", last_rdata, 32'h0);
      check("t1_wdata", last_wdata, 32'h8000_0100);

      preload(12'h304, 32'h0000_0888);
      issue(3'b010, 12'h304, 5'd5, 32'h8);
      wait_idle();
      check("t2_rdata", last_rdata, 32'h888);
      check("t2_wdata", last_wdata, 32'h888);

      issue(3'b111, 12'h304, 5'd8, 32'hFFFF_FFFF);
      wait_idle();
      check("t3_rdata", last_rdata, 32'h888);
      check("t3_wdata", last_wdata, 32'h880);

      preload(12'h341, 32'h1234_5678);
      nw = n_writes;
      issue(3'b010, 12'h341, 5'd0, 32'hFFFF_FFFF);
      wait_idle();
      check("t4_no_write", 32'(n_writes - nw), 32'd0);
      check("t4_rdata", last_rdata, 32'h1234_5678);

      nw = n_writes;
      issue(3'b001, 12'h7C0, 5'd3, 32'hDEAD_BEEF);
      wait_idle();
`ifdef CSR_RMW_ADDR_CHECK_EN
      check("t5_illegal", 32'(last_illegal), 32'd1);
      check("t5_rdata", last_rdata, 32'h0);
      check("t5_no_write", 32'(n_writes - nw), 32'd0);
`else
      check("t5_illegal", 32'(last_illegal), 32'd0);
      check("t5_write", 32'(n_writes - nw), 32'd1);
      check("t5_wdata", last_wdata, 32'hDEAD_BEEF);
`endif

      // reset landing in the WRITE cycle
      nw = n_writes;
      req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h300; req_rs1 = 5'd1;
      req_rs1_data = 32'h5555_AAAA;
      @(negedge clk);
      check("abort_accept", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("abort_we", 32'(csr_we), 32'd0);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_rsp_valid2", 32'(rsp_valid), 32'd0);
      check("abort_we_count", 32'(n_writes - nw), 32'd0);
      @(posedge clk);
      #1;

      // back-pressure: response must hold
      rdy_mode = 2;
      issue(3'b010, 12'h304, 5'd0, 32'h0);
      begin
         int n;
         n = 0;
         while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("hold_rsp_seen", 32'(rsp_valid), 32'd1);
      end
      repeat (5) begin
         @(negedge clk);
         check("hold_req_ready", 32'(req_ready), 32'd0);
         check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      end
      rdy_mode = 1;
      wait_idle();
      check("hold_rdata", last_rdata, 32'h880);

      rdy_mode = 0;
      for (int i = 0; i < 150; i++) begin
         logic [11:0] a;
         logic [4:0]  r;
         a = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 9)];
         r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         issue(3'($urandom), a, r, $urandom);
      end
      rdy_mode = 1;
      wait_idle();
      check("end_wq_empty", 32'(wq.size()), 32'd0);
      check("end_rq_empty", 32'(rq.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
